// File: rtl/i2c_eeprom_follower.sv
// I2C follower emulating a 24LC256-style serial EEPROM backed by an internal byte array.
// Optional write-protect input WP is enabled by defining I2C_FOLLOWER_WP_EN.
module i2c_eeprom_follower #(
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned PAGE_W   = 6,
  parameter logic [2:0]  DEV_ADDR = 3'b000
) (
  input  logic              CLK_50MHz,
  input  logic              RESET,
  input  logic              SCL,
  inout  wire               SDA,
  output logic              WR_VALID,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [7:0]        WR_DATA,
  output logic              BUSY,
  input  logic [ADDR_W-1:0] DBG_ADDR,
  output logic [7:0]        DBG_DATA
`ifdef I2C_FOLLOWER_WP_EN
  ,
  input  logic              WP
`endif
);

  localparam int unsigned       DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PAGE_MASK = ADDR_W'((1 << PAGE_W) - 1);

  typedef enum logic [3:0] {
    IDLE, CTRL, CTRL_ACK, ADDR_HI, ADDR_HI_ACK, ADDR_LO, ADDR_LO_ACK,
    WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [6:0]        addr_hi_q, addr_hi_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              sda_oe_q, sda_oe_d;
  logic              busy_q, busy_d;
  logic              wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              mem_we_s;
  logic [7:0]        mem_q [DEPTH];

  logic scl_s1_q, scl_s2_q, scl_prev_q;
  logic sda_s1_q, sda_s2_q, sda_prev_q;
  logic scl_rise_s, scl_fall_s, scl_high_s, start_s, stop_s;
  logic rx_state_s, rx_bit_s, byte_done_s, ctrl_match_s, wp_s;
  logic [7:0]        rd_byte_s;
  logic [ADDR_W-1:0] page_inc_s;

  // Synchronizers reset to the idle-bus level so reset release never fakes an edge.
  always_ff @(posedge CLK_50MHz or negedge RESET) begin
    if (!RESET) begin
      scl_s1_q   <= 1'b1;
      scl_s2_q   <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_s1_q   <= 1'b1;
      sda_s2_q   <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_s1_q   <= SCL;
      scl_s2_q   <= scl_s1_q;
      scl_prev_q <= scl_s2_q;
      sda_s1_q   <= SDA;
      sda_s2_q   <= sda_s1_q;
      sda_prev_q <= sda_s2_q;
    end
  end

`ifdef I2C_FOLLOWER_WP_EN
  logic wp_s1_q, wp_s2_q;
  always_ff @(posedge CLK_50MHz or negedge RESET) begin
    if (!RESET) begin
      wp_s1_q <= 1'b0;
      wp_s2_q <= 1'b0;
    end else begin
      wp_s1_q <= WP;
      wp_s2_q <= wp_s1_q;
    end
  end
  assign wp_s = wp_s2_q;
`else
  assign wp_s = 1'b0;
`endif

  assign scl_rise_s   = scl_s2_q & ~scl_prev_q;
  assign scl_fall_s   = ~scl_s2_q & scl_prev_q;
  assign scl_high_s   = scl_s2_q & scl_prev_q;
  assign start_s      = scl_high_s & sda_prev_q & ~sda_s2_q;
  assign stop_s       = scl_high_s & ~sda_prev_q & sda_s2_q;
  assign rx_state_s   = (state_q == CTRL) || (state_q == ADDR_HI) ||
                        (state_q == ADDR_LO) || (state_q == WDATA);
  assign rx_bit_s     = rx_state_s && scl_rise_s && (bit_cnt_q != 4'd8);
  assign byte_done_s  = scl_fall_s && (bit_cnt_q == 4'd8);
  assign ctrl_match_s = (shift_q[7:4] == 4'b1010) && (shift_q[3:1] == DEV_ADDR);
  assign rd_byte_s    = mem_q[ptr_q];
  // Writes wrap inside the current page; only the in-page bits advance.
  assign page_inc_s   = (ptr_q & ~PAGE_MASK) | ((ptr_q + ADDR_W'(1)) & PAGE_MASK);

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    addr_hi_d  = addr_hi_q;
    ptr_d      = ptr_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    mem_we_s   = 1'b0;
    if (stop_s) begin
      state_d   = IDLE;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = 4'd0;
    end else if (start_s) begin
      state_d   = CTRL;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = 4'd0;
    end else if (rx_bit_s) begin
      shift_d   = {shift_q[6:0], sda_s2_q};
      bit_cnt_d = bit_cnt_q + 4'd1;
    end else begin
      case (state_q)
        CTRL: begin
          if (byte_done_s && ctrl_match_s) begin
            sda_oe_d  = 1'b1;
            busy_d    = 1'b1;
            bit_cnt_d = 4'd0;
            state_d   = CTRL_ACK;
          end else if (byte_done_s) begin
            state_d = WAIT_STOP;
          end else begin
            state_d = CTRL;
          end
        end
        ADDR_HI: begin
          if (byte_done_s) begin
            addr_hi_d = shift_q[6:0];
            sda_oe_d  = 1'b1;
            bit_cnt_d = 4'd0;
            state_d   = ADDR_HI_ACK;
          end else begin
            state_d = ADDR_HI;
          end
        end
        ADDR_LO: begin
          if (byte_done_s) begin
            ptr_d     = ADDR_W'({addr_hi_q, shift_q});
            sda_oe_d  = 1'b1;
            bit_cnt_d = 4'd0;
            state_d   = ADDR_LO_ACK;
          end else begin
            state_d = ADDR_LO;
          end
        end
        WDATA: begin
          if (byte_done_s && wp_s) begin
            busy_d  = 1'b0;
            state_d = WAIT_STOP;
          end else if (byte_done_s) begin
            mem_we_s   = 1'b1;
            wr_valid_d = 1'b1;
            wr_addr_d  = ptr_q;
            wr_data_d  = shift_q;
            ptr_d      = page_inc_s;
            sda_oe_d   = 1'b1;
            bit_cnt_d  = 4'd0;
            state_d    = WDATA_ACK;
          end else begin
            state_d = WDATA;
          end
        end
        CTRL_ACK: begin
          if (scl_fall_s && shift_q[0]) begin
            shift_d   = rd_byte_s;
            sda_oe_d  = ~rd_byte_s[7];
            bit_cnt_d = 4'd0;
            state_d   = RDATA;
          end else if (scl_fall_s) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
            state_d   = ADDR_HI;
          end else begin
            state_d = CTRL_ACK;
          end
        end
        ADDR_HI_ACK: begin
          if (scl_fall_s) begin
            sda_oe_d = 1'b0;
            state_d  = ADDR_LO;
          end else begin
            state_d = ADDR_HI_ACK;
          end
        end
        ADDR_LO_ACK, WDATA_ACK: begin
          if (scl_fall_s) begin
            sda_oe_d = 1'b0;
            state_d  = WDATA;
          end else begin
            state_d = state_q;
          end
        end
        RDATA: begin
          if (scl_fall_s && (bit_cnt_q == 4'd7)) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
            state_d   = RDATA_ACK;
          end else if (scl_fall_s) begin
            shift_d   = {shift_q[6:0], 1'b0};
            sda_oe_d  = ~shift_q[6];
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else begin
            state_d = RDATA;
          end
        end
        RDATA_ACK: begin
          // Pointer advances on the leader's ACK/NACK sample, wrapping over the full array.
          if (scl_rise_s) begin
            ptr_d = ptr_q + ADDR_W'(1);
            if (sda_s2_q) begin
              busy_d  = 1'b0;
              state_d = WAIT_STOP;
            end else begin
              state_d = RDATA_ACK;
            end
          end else if (scl_fall_s) begin
            shift_d   = rd_byte_s;
            sda_oe_d  = ~rd_byte_s[7];
            bit_cnt_d = 4'd0;
            state_d   = RDATA;
          end else begin
            state_d = RDATA_ACK;
          end
        end
        IDLE, WAIT_STOP: begin
          sda_oe_d = 1'b0;
        end
        default: begin
          sda_oe_d = 1'b0;
          state_d  = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK_50MHz or negedge RESET) begin
    if (!RESET) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'd0;
      addr_hi_q  <= 7'd0;
      ptr_q      <= '0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      addr_hi_q  <= addr_hi_d;
      ptr_q      <= ptr_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Array contents survive reset.
  always_ff @(posedge CLK_50MHz) begin
    if (mem_we_s) begin
      mem_q[ptr_q] <= shift_q;
    end
  end

  assign SDA      = sda_oe_q ? 1'b0 : 1'bz;
  assign WR_VALID = wr_valid_q;
  assign WR_ADDR  = wr_addr_q;
  assign WR_DATA  = wr_data_q;
  assign BUSY     = busy_q;
  assign DBG_DATA = mem_q[DBG_ADDR];

endmodule

// File: tb/tb_i2c_eeprom_follower.sv
// Randomized self-checking bench: bit-banged I2C leader plus an array/pointer reference model.
module tb_i2c_eeprom_follower;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          scl_r;
  logic          ldr_oe;
  wire           sda_w;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          busy;
  logic [AW-1:0] dbg_addr;
  logic [7:0]    dbg_data;
`ifdef I2C_FOLLOWER_WP_EN
  logic          wp_r;
`endif

  pullup (sda_w);
  assign sda_w = ldr_oe ? 1'b0 : 1'bz;
  always #10 clk = ~clk;

  i2c_eeprom_follower #(.ADDR_W(AW), .PAGE_W(6), .DEV_ADDR(3'b000)) dut (
    .CLK_50MHz(clk),
    .RESET(rst_n),
    .SCL(scl_r),
    .SDA(sda_w),
    .WR_VALID(wr_valid),
    .WR_ADDR(wr_addr),
    .WR_DATA(wr_data),
    .BUSY(busy),
    .DBG_ADDR(dbg_addr),
    .DBG_DATA(dbg_data)
`ifdef I2C_FOLLOWER_WP_EN
    ,
    .WP(wp_r)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;
  int mon_addr[$];
  int mon_data[$];
  int drv_cnt = 0;
  logic [7:0] ref_mem [512];
  bit         ref_vld [512];
  int         ref_ptr;
  logic [7:0] wbuf [8];

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Committed writes and any cycle where the follower pulls SDA low on its own.
  always @(negedge clk) begin
    if (wr_valid === 1'b1) begin
      mon_addr.push_back(int'(wr_addr));
      mon_data.push_back(int'(wr_data));
    end
    if (!ldr_oe && sda_w === 1'b0) drv_cnt++;
  end

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v);
    tick(5); ldr_oe = ~v; tick(5); scl_r = 1'b1; tick(10); scl_r = 1'b0;
  endtask

  task automatic recv_bit(output logic v);
    tick(5); ldr_oe = 1'b0; tick(5); scl_r = 1'b1; tick(5); v = sda_w; tick(5); scl_r = 1'b0;
  endtask

  task automatic i2c_start;
    tick(5); ldr_oe = 1'b0; tick(5); scl_r = 1'b1; tick(5); ldr_oe = 1'b1; tick(5); scl_r = 1'b0;
  endtask

  task automatic i2c_stop;
    tick(5); ldr_oe = 1'b1; tick(5); scl_r = 1'b1; tick(5); ldr_oe = 1'b0; tick(10);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic acked);
    logic v;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(v);
    acked = ~v;
  endtask

  task automatic read_byte(output logic [7:0] b, input logic give_ack);
    logic v;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      recv_bit(v);
      b = {b[6:0], v};
    end
    send_bit(~give_ack);
  endtask

  task automatic do_write(input logic [15:0] waddr, input int n, input string tag);
    logic a;
    int   b0, base, ad;
    b0 = mon_addr.size();
    i2c_start;
    write_byte(8'hA0, a);        check_val({tag, "_ctl_ack"}, 32'(a), 1);
    check_val({tag, "_busy"}, 32'(busy), 1);
    write_byte(waddr[15:8], a);  check_val({tag, "_ahi_ack"}, 32'(a), 1);
    write_byte(waddr[7:0], a);   check_val({tag, "_alo_ack"}, 32'(a), 1);
    for (int i = 0; i < n; i++) begin
      write_byte(wbuf[i], a);
      check_val({tag, "_dat_ack"}, 32'(a), 1);
    end
    i2c_stop;
    check_val({tag, "_busy_end"}, 32'(busy), 0);
    check_val({tag, "_wr_cnt"}, mon_addr.size() - b0, n);
    base = 32'(waddr) & 511;
    for (int i = 0; i < n; i++) begin
      ad = (base & ~63) | ((base + i) & 63);
      ref_mem[ad] = wbuf[i];
      ref_vld[ad] = 1'b1;
      if (b0 + i < mon_addr.size()) begin
        check_val({tag, "_wr_addr"}, mon_addr[b0 + i], ad);
        check_val({tag, "_wr_data"}, mon_data[b0 + i], 32'(wbuf[i]));
      end
    end
    for (int i = 0; i < n; i++) begin
      ad = (base & ~63) | ((base + i) & 63);
      dbg_addr = AW'(ad);
      #1;
      check_val({tag, "_dbg"}, 32'(dbg_data), 32'(ref_mem[ad]));
    end
    ref_ptr = (base & ~63) | ((base + n) & 63);
  endtask

  task automatic do_read(input bit rnd, input logic [15:0] raddr, input int n, input string tag);
    logic       a;
    logic [7:0] b;
    if (rnd) begin
      i2c_start;
      write_byte(8'hA0, a);        check_val({tag, "_wctl_ack"}, 32'(a), 1);
      write_byte(raddr[15:8], a);  check_val({tag, "_ahi_ack"}, 32'(a), 1);
      write_byte(raddr[7:0], a);   check_val({tag, "_alo_ack"}, 32'(a), 1);
      ref_ptr = 32'(raddr) & 511;
    end
    i2c_start;
    write_byte(8'hA1, a);
    check_val({tag, "_rctl_ack"}, 32'(a), 1);
    for (int i = 0; i < n; i++) begin
      read_byte(b, i != n - 1);
      if (ref_vld[ref_ptr]) check_val({tag, "_data"}, 32'(b), 32'(ref_mem[ref_ptr]));
      ref_ptr = (ref_ptr + 1) % 512;
    end
    check_val({tag, "_busy_nack"}, 32'(busy), 0);
    i2c_stop;
  endtask

  initial begin
    logic       a;
    logic [7:0] ctl;
    logic [15:0] wa;
    int         n, b0, drv0;

    for (int i = 0; i < 512; i++) begin
      ref_mem[i] = 8'h00;
      ref_vld[i] = 1'b0;
    end
    ref_ptr  = 0;
    rst_n    = 1'b0;
    scl_r    = 1'b1;
    ldr_oe   = 1'b0;
    dbg_addr = '0;
`ifdef I2C_FOLLOWER_WP_EN
    wp_r     = 1'b0;
`endif
    tick(3);
    check_val("rst_wr_valid", 32'(wr_valid), 0);
    check_val("rst_wr_addr", 32'(wr_addr), 0);
    check_val("rst_wr_data", 32'(wr_data), 0);
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_sda", 32'(sda_w), 1);
    rst_n = 1'b1;
    tick(10);

    // Single byte write.
    wbuf[0] = 8'h3C;
    do_write(16'h0005, 1, "t1");

    // Page wrap 0x03E -> 0x001.
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
    do_write(16'h003E, 4, "t2");

    // Wrong chip-select bits: never acknowledged, no writes, not busy.
    drv0 = drv_cnt;
    b0   = mon_addr.size();
    i2c_start;
    write_byte(8'hA2, a);
    check_val("t3_ctl_nack", 32'(a), 0);
    check_val("t3_busy", 32'(busy), 0);
    write_byte(8'h00, a);
    check_val("t3_byte_nack", 32'(a), 0);
    i2c_stop;
    check_val("t3_sda_driven", drv_cnt - drv0, 0);
    check_val("t3_wr_cnt", mon_addr.size() - b0, 0);
    wbuf[0] = 8'h5A;
    do_write(16'h0100, 1, "t3_after");

    // Random sequential read, then a current-address read continuing from it.
    wbuf[0] = 8'h77; wbuf[1] = 8'hC5;
    do_write(16'h0006, 2, "t4_pre");
    do_read(1'b1, 16'h0005, 2, "t4_rrd");
    do_read(1'b0, 16'h0000, 1, "t4_crd");

    // Reset while the control-byte ACK is driven.
    ctl = 8'hA0;
    i2c_start;
    for (int i = 7; i >= 0; i--) send_bit(ctl[i]);
    tick(1);
    ldr_oe = 1'b0;
    tick(5);
    check_val("t5_ack_driven", 32'(sda_w), 0);
    check_val("t5_busy_pre", 32'(busy), 1);
    #3 rst_n = 1'b0;
    #2;
    check_val("t5_sda_released", 32'(sda_w), 1);
    check_val("t5_busy_rst", 32'(busy), 0);
    tick(3);
    rst_n   = 1'b1;
    ref_ptr = 0;
    scl_r   = 1'b1;
    tick(10);
    do_read(1'b0, 16'h0000, 1, "t5_crd");
    wbuf[0] = 8'hE7;
    do_write(16'h0020, 1, "t5_wr");

`ifdef I2C_FOLLOWER_WP_EN
    wbuf[0] = 8'h9A;
    do_write(16'h0010, 1, "wp_pre");
    wp_r = 1'b1;
    tick(4);
    b0 = mon_addr.size();
    i2c_start;
    write_byte(8'hA0, a); check_val("wp_ctl_ack", 32'(a), 1);
    write_byte(8'h00, a); check_val("wp_ahi_ack", 32'(a), 1);
    write_byte(8'h10, a); check_val("wp_alo_ack", 32'(a), 1);
    write_byte(8'h55, a); check_val("wp_dat_nack", 32'(a), 0);
    i2c_stop;
    wp_r = 1'b0;
    check_val("wp_wr_cnt", mon_addr.size() - b0, 0);
    dbg_addr = AW'(16);
    #1;
    check_val("wp_array", 32'(dbg_data), 32'(ref_mem[16]));
`endif

    // Randomized writes, each read back randomly, then a short current-address read.
    for (int it = 0; it < 8; it++) begin
      wa = 16'($urandom);
      n  = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom);
      do_write(wa, n, "rnd_wr");
      do_read(1'b1, wa, $urandom_range(1, 4), "rnd_rrd");
      do_read(1'b0, 16'h0000, $urandom_range(1, 2), "rnd_crd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
